// File: rtl/apb_master_arbiter_if.sv
// Bundles the requester-side and APB-side signals of apb_master_arbiter.
// The arbiter connects through the master modport, and the environment connects through the slave modport.
interface apb_master_arbiter_if #(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  // Handshakes: a requester holds req/addr/wdata/we stable until it sees its
  // gnt_o bit (a 1-cycle pulse); its response arrives later as a 1-cycle
  // rvalid_o pulse with rdata_o/err_o; on APB, an ACCESS cycle completes on PREADY=1.
  logic [NB_REQ-1:0]                req_i;
  logic [NB_REQ*APB_ADDR_WIDTH-1:0] addr_i;
  logic [NB_REQ*APB_DATA_WIDTH-1:0] wdata_i;
  logic [NB_REQ-1:0]                we_i;
  logic [NB_REQ-1:0]                gnt_o;
  logic [NB_REQ-1:0]                rvalid_o;
  logic [APB_DATA_WIDTH-1:0]        rdata_o;
  logic                             err_o;
  logic [APB_ADDR_WIDTH-1:0]        paddr_o;
  logic [APB_DATA_WIDTH-1:0]        pwdata_o;
  logic                             pwrite_o;
  logic                             psel_o;
  logic                             penable_o;
  logic [APB_DATA_WIDTH-1:0]        prdata_i;
  logic                             pready_i;
  logic                             pslverr_i;

  modport master (
    input  req_i, addr_i, wdata_i, we_i, prdata_i, pready_i, pslverr_i,
    output gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o,
           psel_o, penable_o
  );

  modport slave (
    output req_i, addr_i, wdata_i, we_i, prdata_i, pready_i, pslverr_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o,
           psel_o, penable_o
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port between NB_REQ requesters.
// It runs the SETUP/ACCESS sequence and routes each response back to the owning requester, with an optional PREADY watchdog.
module apb_master_arbiter #(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  apb_master_arbiter_if.master bus,
  output logic [1:0]          dbg_state
);

  localparam int IDX_W     = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam bit TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam int TO_LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          rr_q;
  logic [IDX_W-1:0]          owner_q;
  logic [IDX_W-1:0]          winner;
  logic                      found;
  logic [IDX_W:0]            cand;
  logic [CNT_W-1:0]          cnt_q;
  logic                      timeout_hit;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic [NB_REQ-1:0]         gnt;
  logic [NB_REQ-1:0]         rvalid;
  logic                      psel;
  logic                      penable;

  // Search upward from the rr pointer with wrap-around; the first active request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NB_REQ)) begin
        cand = cand - (IDX_W + 1)'(NB_REQ);
      end
      if (!found && bus.req_i[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign timeout_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));

  always_comb begin
    state_d = state_q;
    gnt     = '0;
    rvalid  = '0;
    psel    = 1'b0;
    penable = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt[winner] = 1'b1;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        psel    = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (bus.pready_i || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rvalid[owner_q] = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            paddr_q  <= bus.addr_i[int'(winner)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            pwdata_q <= bus.wdata_i[int'(winner)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            pwrite_q <= bus.we_i[winner];
            owner_q  <= winner;
            rr_q     <= (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        S_ACCESS: begin
          if (!bus.pready_i && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
          // A slave that answers on the watchdog's last cycle still gets its real response.
          if (bus.pready_i) begin
            rdata_q <= pwrite_q ? '0 : bus.prdata_i;
            err_q   <= bus.pslverr_i;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        S_RESP: begin
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt_o     = gnt;
  assign bus.rvalid_o  = rvalid;
  assign bus.rdata_o   = rdata_q;
  assign bus.err_o     = err_q;
  assign bus.paddr_o   = paddr_q;
  assign bus.pwdata_o  = pwdata_q;
  assign bus.pwrite_o  = pwrite_q;
  assign bus.psel_o    = psel;
  assign bus.penable_o = penable;
  assign dbg_state     = state_q;

endmodule
